// File: rtl/lstm_acc_pkg.sv
// Shared definitions for the LSTM accelerator datapath: default array geometry,
// feeder FSM states and the packed weight word carried to the PE array.
package lstm_acc_pkg;

   localparam int ELEMENT_BITS_DEFAULT = 8;
   localparam int P_DEFAULT            = 4;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DRAIN,
      DONE
   } feeder_state_t;

   typedef logic [P_DEFAULT*ELEMENT_BITS_DEFAULT-1:0] weight_word_t;

endpackage

// File: rtl/feeder_skid_buf.sv
// Two-entry registered valid/ready buffer between the beat source and the step
// logic; a push and a pop in the same cycle leave the occupancy unchanged.
module feeder_skid_buf
   import lstm_acc_pkg::*;
#(
   parameter int WIDTH = 40
) (
   input  logic             sys_clk,
   input  logic             reset,
   input  logic             push_valid,
   output logic             push_ready,
   input  logic [WIDTH-1:0] push_data,
   output logic             pop_valid,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data
);

   logic [WIDTH-1:0] slot [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;
   logic             do_push;
   logic             do_pop;

   assign push_ready = (count != 2'd2);
   assign pop_valid  = (count != 2'd0);
   assign pop_data   = slot[rd_ptr];
   assign do_push    = push_valid && push_ready;
   assign do_pop     = pop && pop_valid;

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         slot[0] <= '0;
         slot[1] <= '0;
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         count   <= 2'd0;
      end else begin
         if (do_push) begin
            slot[wr_ptr] <= push_data;
            wr_ptr       <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pe_array_feeder.sv
// Paces (weight, input) beats into the systolic PE array with a pe_step strobe
// every PE_DIV cycles (legal 2..16), then flushes it with 2*P-1 zero steps.
// Optional FEEDER_BIAS_EN adds bias_in, used as the partial-sum seed on stream steps.
module pe_array_feeder
   import lstm_acc_pkg::*;
#(
   parameter int ELEMENT_BITS = ELEMENT_BITS_DEFAULT,
   parameter int P            = P_DEFAULT,
   parameter int PE_DIV       = 4,
   parameter int MAX_LEN      = 256
) (
   input  logic                            sys_clk,
   input  logic                            reset,
   input  logic                            start,
   input  logic [$clog2(MAX_LEN+1)-1:0]    job_len,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [P*ELEMENT_BITS-1:0]       in_weight,
   input  logic [ELEMENT_BITS-1:0]         in_data,
   output logic [P*ELEMENT_BITS-1:0]       weight_data_in,
   output logic [ELEMENT_BITS-1:0]         input_data_in,
   output logic [ELEMENT_BITS-1:0]         output_data_in,
   output logic                            pe_step,
   output logic                            busy,
   output logic                            done
`ifdef FEEDER_BIAS_EN
   ,
   input  logic [ELEMENT_BITS-1:0]         bias_in
`endif
);

   localparam int LEN_W   = $clog2(MAX_LEN+1);
   localparam int DIV_W   = $clog2(PE_DIV);
   localparam int DRAIN_W = $clog2(2*P);
   localparam int W_BITS  = P*ELEMENT_BITS;
   localparam int BEAT_W  = W_BITS + ELEMENT_BITS;
   localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(PE_DIV-1);
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(2*P-2);

   feeder_state_t        state;
   logic [DIV_W-1:0]     div_cnt;
   logic [LEN_W-1:0]     len_reg;
   logic [LEN_W-1:0]     acc_cnt;
   logic [LEN_W-1:0]     rem_cnt;
   logic [DRAIN_W-1:0]   drain_cnt;
   logic                 buf_ready;
   logic                 buf_valid;
   logic [BEAT_W-1:0]    buf_beat;
   logic                 div_expired;
   logic                 accept;
   logic                 step_stream;
`ifdef FEEDER_BIAS_EN
   logic [ELEMENT_BITS-1:0] bias_reg;
`endif

   assign div_expired = (div_cnt == DIV_LAST);
   assign in_ready    = (state == STREAM) && buf_ready && (acc_cnt < len_reg);
   assign accept      = in_valid && in_ready;
   assign step_stream = (state == STREAM) && div_expired && buf_valid;

   feeder_skid_buf #(
      .WIDTH(BEAT_W)
   ) skid (
      .sys_clk    (sys_clk),
      .reset      (reset),
      .push_valid (accept),
      .push_ready (buf_ready),
      .push_data  ({in_weight, in_data}),
      .pop_valid  (buf_valid),
      .pop        (step_stream),
      .pop_data   (buf_beat)
   );

   // The divider parks at its terminal value while the buffer is empty, so a
   // late beat steps on the cycle right after it lands.
   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         div_cnt        <= '0;
         len_reg        <= '0;
         acc_cnt        <= '0;
         rem_cnt        <= '0;
         drain_cnt      <= '0;
         weight_data_in <= '0;
         input_data_in  <= '0;
         output_data_in <= '0;
         pe_step        <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
`ifdef FEEDER_BIAS_EN
         bias_reg       <= '0;
`endif
      end else begin
         pe_step <= 1'b0;
         done    <= 1'b0;
         unique case (state)
            IDLE: begin
               div_cnt <= '0;
               if (start) begin
                  len_reg   <= job_len;
                  rem_cnt   <= job_len;
                  acc_cnt   <= '0;
                  drain_cnt <= '0;
                  busy      <= 1'b1;
`ifdef FEEDER_BIAS_EN
                  bias_reg  <= bias_in;
`endif
                  state     <= (job_len != '0) ? STREAM : DRAIN;
               end
            end
            STREAM: begin
               if (accept) begin
                  acc_cnt <= acc_cnt + LEN_W'(1);
               end
               if (div_expired) begin
                  if (buf_valid) begin
                     pe_step        <= 1'b1;
                     weight_data_in <= buf_beat[BEAT_W-1 -: W_BITS];
                     input_data_in  <= buf_beat[ELEMENT_BITS-1:0];
`ifdef FEEDER_BIAS_EN
                     output_data_in <= bias_reg;
`else
                     output_data_in <= '0;
`endif
                     div_cnt        <= '0;
                     rem_cnt        <= rem_cnt - LEN_W'(1);
                     if (rem_cnt == LEN_W'(1)) begin
                        state <= DRAIN;
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            DRAIN: begin
               if (div_expired) begin
                  pe_step        <= 1'b1;
                  weight_data_in <= '0;
                  input_data_in  <= '0;
                  output_data_in <= '0;
                  div_cnt        <= '0;
                  drain_cnt      <= drain_cnt + DRAIN_W'(1);
                  if (drain_cnt == DRAIN_LAST) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            DONE: begin
               busy    <= 1'b0;
               div_cnt <= '0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/pe_array_feeder.md
# pe_array_feeder

Upstream stage of the systolic PE array. Accepts a matrix-vector job as a valid/ready stream of (weight word, input element) beats, paces them into the array at one step every PE_DIV sys_clk cycles, seeds the partial-sum chain, then flushes the array with zero steps and signals completion. It replaces the free-running pe_clk with a single-clock step strobe, so the array advances on `pe_step` only.

## Interface
- ELEMENT_BITS, 8, width of one element
- P, 4, number of PEs in the array
- PE_DIV, 4, sys_clk cycles per array step; legal range 2..16
- MAX_LEN, 256, maximum job length in beats
- sys_clk  in  1  sole clock
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle job start pulse; honoured in IDLE only
- job_len  in  $clog2(MAX_LEN+1)  beats in the job, sampled on start; 0 is legal
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_weight  in  P*ELEMENT_BITS  weight word for one step
- in_data  in  ELEMENT_BITS  input element for one step
- weight_data_in  out  P*ELEMENT_BITS  to array
- input_data_in  out  ELEMENT_BITS  to array
- output_data_in  out  ELEMENT_BITS  partial-sum seed to array
- pe_step  out  1  one-cycle strobe; the array advances on this cycle
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at the end of a job

## Operation
- FSM states: IDLE, STREAM, DRAIN, DONE.
- IDLE -> STREAM on start with job_len>0. IDLE -> DRAIN on start with job_len==0. Otherwise stay.
- STREAM: beats pass through a 2-entry skid buffer. A step fires when the divider expires and the buffer is non-empty. The step pops one beat, loads it into the output registers, and decrements the remaining count. When the last beat is stepped, go to DRAIN.
- Buffer empty at divider expiry: stall. No pe_step, outputs hold, and the divider holds at its terminal value until data arrives. The step then fires in the cycle after the beat lands.
- DRAIN: fire 2*P-1 steps at the PE_DIV pace with weight and input driven to zero, then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- in_ready = (state==STREAM) && buffer not full && accepted beats < job_len. Beats beyond job_len are never accepted.
- output_data_in is 0 on every step.
- start outside IDLE is ignored.
- All arithmetic is unsigned counters. Elements are passed through unmodified.

## Timing
- Reset values: in_ready=0, busy=0, done=0, pe_step=0, all data outputs 0. FSM=IDLE, divider=0, buffer empty.
- Divider runs only in STREAM and DRAIN, and restarts at 0 on entry to STREAM.
- First step occurs at the earliest PE_DIV cycles after start, given a beat was accepted the cycle after start.
- Data outputs are registered. They change on the same edge that raises pe_step and are stable for at least PE_DIV cycles.
- Accept-to-step latency is at least 1 cycle, because the skid buffer is registered.
- Simultaneous push and pop in one cycle is legal and leaves the occupancy unchanged.
- done is asserted exactly (2*P-1)*PE_DIV cycles after the last stream step, absent stalls. busy falls together with done.
- Reset asserted mid-job returns to reset values immediately, whatever the state. Buffered beats are discarded.

## Configuration
- FEEDER_BIAS_EN defined:
  - Adds port `bias_in` (in, ELEMENT_BITS), sampled on start.
  - output_data_in = bias on each STREAM step and 0 on DRAIN steps.
- FEEDER_BIAS_EN undefined: no port, and output_data_in is always 0.

## Structure
- Shared package `lstm_acc_pkg` holds:
  - ELEMENT_BITS default
  - P default
  - `feeder_state_t` enum (IDLE/STREAM/DRAIN/DONE)
  - `weight_word_t` typedef (P*ELEMENT_BITS)
- One sub-module, `feeder_skid_buf`: 2-entry valid/ready buffer carrying {weight, data}, parameterised on width.

## Test plan
- P=4, PE_DIV=4, job_len=3, beats always valid: pe_step at 4-cycle spacing, 3 data steps then 7 zero steps, done 28 cycles after the last data step.
- job_len=0: no beat accepted, 7 zero steps, then done; in_ready stays 0 throughout.
- in_valid low for 10 cycles mid-job: pe_step stops, outputs hold; the step fires 1 cycle after the beat lands; the beat count is unchanged.
- Source offers 5 beats with job_len=2: exactly 2 handshakes, in_ready low afterwards.
- reset asserted during DRAIN: the next cycle shows busy=0, pe_step=0, all outputs 0; a new start runs a clean job.
- FEEDER_BIAS_EN, bias_in=8'h05: output_data_in=5 on all STREAM steps and 0 on DRAIN steps.
